digiota_bitstream_decimator: RTL

//  Downstream consumer of the digital-OTA comparator output bit (uo_out[0]).

---
 rtl/digiota_bitstream_decimator_pkg.sv | 19 +
 rtl/digiota_bitstream_decimator_sync.sv | 30 +++
 rtl/digiota_bitstream_decimator.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/digiota_bitstream_decimator_pkg.sv
// Shared types and constants for the digital-OTA bitstream decimator.
package digiota_pkg;

  // Decimator control states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACCUM  = 2'd2
  } state_e;

  // Default depth of the comparator-bit synchroniser.
  localparam int SYNC_STAGES_DEFAULT = 2;

  // Window length in clk cycles for a given log2 size.
  function automatic int win_len(input int log2);
    return 1 << log2;
  endfunction

endpackage

// File: rtl/digiota_bitstream_decimator_sync.sv
// Reset-to-zero flop chain that brings the asynchronous comparator bit into clk.
module digiota_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw bit in at stage 0; the last stage is the usable sample.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Synchroniser register chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/digiota_bitstream_decimator.sv
// Boxcar (CIC-1) decimator for the comparator bitstream: settle, count ones
// over back-to-back 2^WIN_LOG2-cycle windows, present each count on a
// single-entry holding register.
//
// Output handshake: dout is transferred on a clk edge where dout_valid and
// dout_ready are both high. dout_valid never drops without a transfer (or
// reset), and dout is stable while dout_valid is high and not transferred.
module digiota_bitstream_decimator
  import digiota_pkg::*;
#(
  parameter int WIN_LOG2    = 4,
  parameter int SETTLE      = 2,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                cmp_in,
  output logic [WIN_LOG2:0]   dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                overrun,
  output logic                busy
);

  localparam int WIN_LEN     = win_len(WIN_LOG2);
  localparam int SET_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int SETTLE_LAST = (SETTLE > 0) ? SETTLE - 1 : 0;

  localparam logic [WIN_LOG2-1:0] WIN_LAST  = WIN_LOG2'(WIN_LEN - 1);
  localparam logic [WIN_LOG2-1:0] WIN_ONE   = WIN_LOG2'(1);
  localparam logic [SET_W-1:0]    SET_LAST  = SET_W'(SETTLE_LAST);
  localparam logic [SET_W-1:0]    SET_ONE   = SET_W'(1);

  state_e                state_q, state_d;
  logic [SET_W-1:0]      settle_cnt_q, settle_cnt_d;
  logic [WIN_LOG2-1:0]   win_cnt_q, win_cnt_d;
  logic [WIN_LOG2:0]     acc_q, acc_d;
  logic [WIN_LOG2:0]     dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  overrun_q, overrun_d;
  logic                  busy_q, busy_d;

  logic                  s_sync;
  logic                  complete;
  logic [WIN_LOG2:0]     result;
  logic                  pop;

  digiota_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (cmp_in),
    .q   (s_sync)
  );

  // FSM next state and window accumulator; en low overrides everything.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    win_cnt_d    = win_cnt_q;
    acc_d        = acc_q;
    complete     = 1'b0;
    result       = acc_q + (WIN_LOG2 + 1)'(s_sync);

    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          if (SETTLE == 0) begin
            state_d   = ST_ACCUM;
            acc_d     = '0;
            win_cnt_d = '0;
          end else begin
            state_d      = ST_SETTLE;
            settle_cnt_d = '0;
          end
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == SET_LAST) begin
          state_d   = ST_ACCUM;
          acc_d     = '0;
          win_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + SET_ONE;
        end
      end
      ST_ACCUM: begin
        if (win_cnt_q == WIN_LAST) begin
          // Final sample of the window: result carries it, acc restarts.
          complete  = 1'b1;
          acc_d     = '0;
          win_cnt_d = '0;
        end else begin
          acc_d     = result;
          win_cnt_d = win_cnt_q + WIN_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (!en) begin
      state_d      = ST_IDLE;
      complete     = 1'b0;
      acc_d        = '0;
      win_cnt_d    = '0;
      settle_cnt_d = '0;
    end
  end

  // Holding register, overrun flag and busy indication.
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = overrun_q;
    pop          = dout_valid_q & dout_ready;

    if (complete) begin
      if (!dout_valid_q || dout_ready) begin
        // Empty, or being emptied this cycle: take the new count.
        dout_d       = result;
        dout_valid_d = 1'b1;
      end else begin
        // Unread result still held: keep it, drop the new one.
        overrun_d = 1'b1;
      end
    end else if (pop) begin
      dout_valid_d = 1'b0;
    end

    // Overrun is only ever set while running, so en low means en has fallen.
    if (!en) begin
      overrun_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      win_cnt_q    <= '0;
      acc_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      win_cnt_q    <= win_cnt_d;
      acc_q        <= acc_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule
